// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready load
// Optional even-parity trailer bit: define PISO_SERIALIZER_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shreg_shifted;

  // A new word may enter when idle or during the final bit of the current frame.
  assign load_ready = ena && ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0)));
  assign accept     = load_valid && load_ready;

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

  // Bit-order selection: first bit goes straight to sout, the rest waits in the shifter.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit     = load_data[WIDTH-1];
      load_rest     = {load_data[WIDTH-2:0], 1'b0};
      next_bit      = shreg_q[WIDTH-1];
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      first_bit     = load_data[0];
      load_rest     = {1'b0, load_data[WIDTH-1:1]};
      next_bit      = shreg_q[0];
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Next-state and registered-output logic; ena low holds every register.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    sout_d        = sout_q;
    sout_valid_d  = sout_valid_q;
    frame_start_d = frame_start_q;
    busy_d        = busy_q;
`ifdef PISO_SERIALIZER_PARITY_EN
    parity_d      = parity_q;
`endif
    if (accept) begin
      state_d       = SHIFT;
      shreg_d       = load_rest;
      cnt_d         = CNT_LOAD;
      sout_d        = first_bit;
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
      busy_d        = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_d      = ^load_data;
`endif
    end else if (ena) begin
      case (state_q)
        SHIFT: begin
          frame_start_d = 1'b0;
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - CW'(1);
            shreg_d = shreg_shifted;
            sout_d  = next_bit;
`ifdef PISO_SERIALIZER_PARITY_EN
            // Last data bit is on the line; the trailer bit follows.
            if (cnt_q == CW'(1)) begin
              sout_d = parity_q;
            end
`endif
          end else begin
            state_d      = IDLE;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
            busy_d       = 1'b0;
          end
        end
        default: begin
          sout_d        = 1'b0;
          sout_valid_d  = 1'b0;
          frame_start_d = 1'b0;
          busy_d        = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously so a reset abandons any frame.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (MSB-first and LSB-first)
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       clr_n, ena;
  logic [7:0] load_data, load_data_l;
  logic       load_valid, load_valid_l;
  logic       load_ready, load_ready_l;
  logic       sout, sout_valid, frame_start, busy;
  logic       sout_l, sout_valid_l, frame_start_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed { logic b; logic fs; } exp_t;
  exp_t q_m[$];
  exp_t q_l[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clr_n(clr_n), .ena(ena),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clr_n(clr_n), .ena(ena),
    .load_data(load_data_l), .load_valid(load_valid_l), .load_ready(load_ready_l),
    .sout(sout_l), .sout_valid(sout_valid_l), .frame_start(frame_start_l), .busy(busy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input bit lane, input logic [7:0] w, input bit msb);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b  = msb ? w[7-i] : w[i];
      e.fs = (i == 0);
      if (lane) q_l.push_back(e); else q_m.push_back(e);
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    e.b  = ^w;
    e.fs = 1'b0;
    if (lane) q_l.push_back(e); else q_m.push_back(e);
`endif
  endfunction

  // Monitors: a bit is consumed on every enabled edge while sout_valid is high.
  always @(negedge clk) begin
    exp_t e;
    if (clr_n && ena && sout_valid) begin
      if (q_m.size() == 0) chk("m_unexpected_bit", 1, 0);
      else begin
        e = q_m.pop_front();
        chk("m_sout", sout, e.b);
        chk("m_frame_start", frame_start, e.fs);
        chk("m_busy", busy, 1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (clr_n && ena && sout_valid_l) begin
      if (q_l.size() == 0) chk("l_unexpected_bit", 1, 0);
      else begin
        e = q_l.pop_front();
        chk("l_sout", sout_l, e.b);
        chk("l_frame_start", frame_start_l, e.fs);
      end
    end
  end

  // Offer a word and wait (bounded) for acceptance; acc is the cycle number after the accepting edge.
  task automatic send(input bit lane, input logic [7:0] w, output int acc);
    acc = -1;
    if (lane) begin load_data_l = w; load_valid_l = 1'b1; end
    else      begin load_data   = w; load_valid   = 1'b1; end
    for (int k = 0; k < 40 && acc < 0; k++) begin
      @(negedge clk);
      if (lane ? load_ready_l : load_ready) begin
        push_frame(lane, w, !lane);
        @(posedge clk);
        #1;
        acc = cyc;
        if (lane) load_valid_l = 1'b0; else load_valid = 1'b0;
      end
    end
    if (acc < 0) begin
      chk("accept_timeout", 0, 1);
      if (lane) load_valid_l = 1'b0; else load_valid = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    clr_n = 1'b0; ena = 1'b0;
    load_data = '0; load_valid = 1'b0; load_data_l = '0; load_valid_l = 1'b0;
    #22;
    chk("rst_sout", sout, 0);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_ready_ena0", load_ready, 0);
    ena = 1'b1;
    #1;
    chk("rst_load_ready_ena1", load_ready, 1);
    step(1);
    clr_n = 1'b1;
    step(1);

    // Single frame 0xA5
    send(0, 8'hA5, a1);
    chk("single_c1_fs", frame_start, 1);
    chk("single_c1_busy", busy, 1);
    step(FL - 1);
    chk("single_last_busy", busy, 1);
    chk("single_last_ready", load_ready, 1);
    step(1);
    chk("single_after_valid", sout_valid, 0);
    chk("single_after_busy", busy, 0);
    chk("single_after_sout", sout, 0);

    // Back-to-back 0xA5 then 0x3C with no gap
    send(0, 8'hA5, a1);
    send(0, 8'h3C, a2);
    chk("b2b_accept_spacing", a2 - a1, FL);
    chk("b2b_f2_fs", frame_start, 1);
    chk("b2b_f2_valid", sout_valid, 1);
    step(FL);
    chk("b2b_end_busy", busy, 0);

    // Stall: ena low in cycles 3..5 of a 0xF0 frame
    send(0, 8'hF0, a1);
    step(2);
    ena = 1'b0;
    #1;
    chk("stall_c3_ready", load_ready, 0);
    chk("stall_c3_sout", sout, 1);
    for (int c = 4; c <= 5; c++) begin
      step(1);
      chk("stall_hold_sout", sout, 1);
      chk("stall_hold_valid", sout_valid, 1);
      chk("stall_hold_ready", load_ready, 0);
    end
    step(1);
    ena = 1'b1;
    chk("stall_c6_sout", sout, 1);
    step(FL - 3);
    chk("stall_last_valid", sout_valid, 1);
    step(1);
    chk("stall_done_valid", sout_valid, 0);

    // LSB-first 0x01 on the second instance
    send(1, 8'h01, a1);
    chk("lsb_c1_fs", frame_start_l, 1);
    step(FL);
    chk("lsb_done_busy", busy_l, 0);

    // Parity-bearing pattern (extra trailer only when parity is built in)
    send(0, 8'h07, a1);
    step(FL);
    chk("p07_done_busy", busy, 0);

    // Reset mid-frame
    send(0, 8'hFF, a1);
    step(3);
    clr_n = 1'b0;
    ena = 1'b0;
    q_m.delete();
    #1;
    chk("midrst_sout", sout, 0);
    chk("midrst_valid", sout_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fs", frame_start, 0);
    chk("midrst_ready", load_ready, 0);
    step(2);
    chk("midrst_ready_hold", load_ready, 0);
    clr_n = 1'b1;
    ena = 1'b1;
    #1;
    chk("postrst_idle_valid", sout_valid, 0);
    send(0, 8'h81, a1);
    chk("postrst_fs", frame_start, 1);
    step(FL);
    chk("postrst_done_busy", busy, 0);
    step(2);

    chk("q_m_drained", q_m.size(), 0);
    chk("q_l_drained", q_l.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock.
- It is the sending end of the serial bit chains our enable-gated flip-flop stages and shift-in receivers capture. It drives one serial data line plus a qualifier and a frame marker.
- Sits between a word-oriented producer and a serial link or deserializer.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- clr_n  input  1  asynchronous, active-low reset.
- ena  input  1  clock enable; 0 freezes all state for that cycle.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  block accepts a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  high on the first bit of each frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE, shift register=0, bit counter=0.
  - Outputs during reset: sout=0, sout_valid=0, frame_start=0, busy=0.
  - load_ready follows its formula below (IDLE && ena).
- States:
  - IDLE: no frame in progress.
  - SHIFT: a frame is being sent; counter holds bits remaining minus 1.
- load_ready is combinational: ena && (state==IDLE || (state==SHIFT && counter==0)).
- Handshake: a word is accepted on a rising edge where load_valid && load_ready.
  - load_data is sampled only at acceptance.
  - load_data changes while not accepted are ignored.
- Latency: word accepted at edge N → first bit on sout after edge N, i.e. in cycle N+1.
  - Remaining bits follow on subsequent enabled cycles.
  - Frame length is FRAME_LEN enabled cycles: FRAME_LEN=WIDTH, or WIDTH+1 with parity (see Optional Feature).
- Outputs sout, sout_valid, frame_start and busy are all registered.
- sout_valid=busy=1 for every cycle of the frame; frame_start=1 only in the first bit cycle.
- Bit order:
  - MSB_FIRST=1: load_data[WIDTH-1] down to [0].
  - MSB_FIRST=0: [0] up to [WIDTH-1].
- Transitions:
  - IDLE→SHIFT on acceptance; counter loaded with FRAME_LEN-1.
  - SHIFT, counter>0, ena: shift one bit, counter decrements.
  - SHIFT, counter==0, ena, no acceptance → IDLE; sout=0, sout_valid=0, busy=0.
  - SHIFT, counter==0, ena, acceptance → stays SHIFT; new frame starts next cycle with frame_start=1. Back-to-back frames have no gap bit.
- ena=0: no acceptance (load_ready=0); all registers hold, so sout, sout_valid and busy keep their values. A stalled bit is simply presented longer.
- When idle, sout is forced to 0.
- load_valid while busy and counter>0: not accepted; the producer must hold the word.
- Reset mid-frame: the frame is abandoned immediately; no further bits are sent after release.
  - First possible acceptance is the first enabled edge with clr_n high.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - FRAME_LEN=WIDTH+1.
  - After the last data bit, one even-parity bit is sent (XOR of all WIDTH data bits), with sout_valid=1.
  - load_ready for the next word rises only during the parity-bit cycle.
- Undefined:
  - FRAME_LEN=WIDTH, no parity logic.
  - Timing identical to the base description.

Test Plan:
- Single frame: WIDTH=8, MSB_FIRST=1, ena=1. Load 0xA5 at edge 0 → cycles 1..8 sout=1,0,1,0,0,1,0,1. frame_start=1 only in cycle 1. sout_valid=busy=1 in cycles 1..8, then 0 in cycle 9.
- Back-to-back: 0xA5 then 0x3C held valid → load_ready=1 in cycle 8. Cycles 9..16 sout=0,0,1,1,1,1,0,0 with no gap. frame_start pulses in cycles 1 and 9.
- Stall: load 0xF0; drop ena for cycles 3-5 → sout holds bit 2 (value 1) through cycles 3-5. Frame completes in cycle 11; load_ready=0 during the stall.
- LSB-first: MSB_FIRST=0, load 0x01 → sout=1,0,0,0,0,0,0,0.
- Reset mid-frame: load 0xFF, pull clr_n low in cycle 4 → sout, sout_valid, busy go 0 immediately; load_ready=0 until release. After release, new word 0x81 transmits cleanly as 1,0,0,0,0,0,0,1.
- Parity (macro defined): 0xA5 → 9th bit=0; 0x07 → 9th bit=1. sout_valid=1 for 9 cycles per frame.
